// File: rtl/mode_switch_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : breath_pkg
//  Description : Shared constants, conditioner state type and cycle-count
//                helpers for the breathing/flowing LED mode path.
//  Contents    : DEFAULT_CLK_FREQ  - default system clock in Hz
//                cond_state_t      - mode conditioner states
//                ms_to_cycles()    - milliseconds to clock cycles
//                count_width()     - counter width for a terminal count
//  Revision    : 1.0 - initial release
// ============================================================================
package breath_pkg;

    localparam int unsigned DEFAULT_CLK_FREQ = 100_000_000;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_BLANK  = 2'd1,
        S_COMMIT = 2'd2
    } cond_state_t;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                                 input int unsigned ms);
        return (clk_freq / 1000) * ms;
    endfunction

    // Width able to hold 0..terminal without wrapping; never less than 1 bit.
    function automatic int unsigned count_width(input int unsigned terminal);
        return (terminal < 1) ? 1 : $clog2(terminal + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mode_switch_conditioner_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debounce
//  Description : 2-flop synchroniser followed by a stability counter. The
//                output level changes only after the synchronised input has
//                disagreed with it for DB_CYCLES consecutive cycles.
//  Ports       : clk    - system clock
//                rst_n  - synchronous active-low reset
//                din    - asynchronous raw input
//                stable - debounced level
//                rise   - one-cycle pulse on a 0->1 change of stable
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce
    import breath_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic stable,
    output logic rise
);

    localparam int unsigned       CNT_W    = count_width(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // This is the DB_CYCLES-th consecutive disagreeing cycle.
                r_stable <= r_sync2;
                r_rise   <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stable = r_stable;
    assign rise   = r_rise;

endmodule
`default_nettype wire

// File: rtl/mode_switch_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : mode_switch_conditioner
//  Description : Debounces the mode DIP switch and pause button, and applies
//                mode changes only after an LED blanking window.
//  Ports       : clk       - system clock
//                rst_n     - synchronous active-low reset
//                sw_raw    - raw mode switch (0 breathing, 1 flowing)
//                btn_raw   - raw pause button, active-high
//                mode      - committed mode
//                blank     - force LED bus off
//                mode_chg  - one-cycle pulse when mode changes
//                pause     - pause flag, toggled by button presses
//                sw_stable - debounced switch level
//  Revision    : 1.0 - initial release
// ============================================================================
module mode_switch_conditioner
    import breath_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = DEFAULT_CLK_FREQ,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned BLANK_MS    = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    input  logic btn_raw,
    output logic mode,
    output logic blank,
    output logic mode_chg,
    output logic pause,
    output logic sw_stable
);

    localparam int unsigned MS_CYCLES    = ms_to_cycles(CLK_FREQ, 1);
    localparam int unsigned DB_CYCLES    = MS_CYCLES * DEBOUNCE_MS;
    localparam int unsigned BLANK_CYCLES = MS_CYCLES * BLANK_MS;

    localparam int unsigned        TIMER_W    = count_width(BLANK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BLANK_CYCLES - 1);

    logic w_sw_db;
    logic w_sw_rise;
    logic w_btn_db;
    logic w_btn_rise;
    logic w_commit;
    logic w_unused;

    cond_state_t        r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_sw_stable;
    logic               r_btn_rise;
    logic               r_mode;
    logic               r_blank;
    logic               r_mode_chg;
    logic               r_pause;

    switch_debounce #(.DB_CYCLES(DB_CYCLES)) u_sw_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (sw_raw),
        .stable (w_sw_db),
        .rise   (w_sw_rise)
    );

    switch_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (btn_raw),
        .stable (w_btn_db),
        .rise   (w_btn_rise)
    );

    // Switch edge pulse and button level are not needed here.
    assign w_unused = w_sw_rise ^ w_btn_db;

    // A real commit: last blanking cycle and the debounced switch still
    // disagrees with the committed mode.
    assign w_commit = (r_state == S_BLANK) && (r_timer == TIMER_LAST)
                   && (r_sw_stable != r_mode);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_timer     <= '0;
            r_sw_stable <= 1'b0;
            r_btn_rise  <= 1'b0;
            r_mode      <= 1'b0;
            r_blank     <= 1'b0;
            r_mode_chg  <= 1'b0;
            r_pause     <= 1'b0;
        end else begin
            // Debouncer outputs are re-registered so both input paths see the
            // same one-cycle delay before the FSM and pause logic act on them.
            r_sw_stable <= w_sw_db;
            r_btn_rise  <= w_btn_rise;
            r_mode_chg  <= 1'b0;

            case (r_state)
                S_RUN: begin
                    r_blank <= 1'b0;
                    if (r_sw_stable != r_mode) begin
                        r_state <= S_BLANK;
                        r_timer <= '0;
                        r_blank <= 1'b1;
                    end
                end
                S_BLANK: begin
                    r_blank <= 1'b1;
                    if (r_timer == TIMER_LAST) begin
                        // A switch that bounced back commits the same value,
                        // so mode_chg stays low.
                        r_state    <= S_COMMIT;
                        r_mode     <= r_sw_stable;
                        r_mode_chg <= (r_sw_stable != r_mode);
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_blank <= 1'b0;
                    r_timer <= '0;
                    r_state <= S_RUN;
                end
                default: begin
                    r_blank <= 1'b0;
                    r_state <= S_RUN;
                end
            endcase

            // A commit overrides a simultaneous button press.
            if (w_commit) begin
                r_pause <= 1'b0;
            end else if (r_btn_rise) begin
                r_pause <= ~r_pause;
            end
        end
    end

    assign mode      = r_mode;
    assign blank     = r_blank;
    assign mode_chg  = r_mode_chg;
    assign pause     = r_pause;
    assign sw_stable = r_sw_stable;

endmodule
`default_nettype wire
